// File: rtl/bcd_pkg.sv
// Shared constants, FSM encoding and helpers for the serial BCD add/subtract unit.
package bcd_pkg;

  localparam int         DIGIT_W  = 4;
  localparam logic [3:0] BCD_MAX  = 4'd9;
  localparam logic [3:0] BCD_CORR = 4'd6;

  // FSM encoding, kept as plain constants so legacy code can share it.
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Nines complement of one BCD digit; meaningless for digits above 9,
  // which are flagged separately and never reach the outputs.
  function automatic logic [3:0] nines_comp(input logic [3:0] d);
    return BCD_MAX - d;
  endfunction

endpackage

// File: rtl/bcd_digit_addsub.sv
// Combinational single-digit BCD add/subtract cell with decimal correction.
import bcd_pkg::*;

module bcd_digit_addsub (
  input  logic [3:0] xd,
  input  logic [3:0] yd,
  input  logic       cin,
  input  logic       sub,
  output logic [3:0] digit,
  output logic       cout,
  output logic       invalid
);

  logic [3:0] yd_eff;
  logic [4:0] sum;
  logic [4:0] corr;

  // Binary sum of the digits, then +6 correction whenever it leaves 0..9.
  always_comb begin
    // NOTE: every output of a combinational block gets a value on every path,
    // otherwise synthesis infers a latch to hold the old one.
    yd_eff  = sub ? nines_comp(yd) : yd;
    sum     = {1'b0, xd} + {1'b0, yd_eff} + {4'b0000, cin};
    corr    = sum + {1'b0, BCD_CORR};
    digit   = sum[3:0];
    cout    = 1'b0;
    if (sum > {1'b0, BCD_MAX}) begin
      digit = corr[3:0];
      cout  = 1'b1;
    end
    invalid = (xd > BCD_MAX) || (yd > BCD_MAX);
  end

endmodule

// File: rtl/bcd_serial_addsub.sv
// Digit-serial N-digit BCD adder/subtractor, LSD first, start/ready/done handshake.
import bcd_pkg::*;

module bcd_serial_addsub #(
  parameter int NDIGITS = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic                   mode_sub,
  input  logic                   c_in,
  input  logic [4*NDIGITS-1:0]   X,
  input  logic [4*NDIGITS-1:0]   Y,
  output logic                   ready,
  output logic                   done,
  output logic [4*NDIGITS-1:0]   result,
  output logic                   c_out,
  output logic                   out_of_range
);

  localparam int W     = DIGIT_W * NDIGITS;
  localparam int CNT_W = $clog2(NDIGITS + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NDIGITS - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [W-1:0]     x_sh;
  logic [W-1:0]     y_sh;
  logic [W-1:0]     shadow;
  logic             carry;
  logic             sub_r;
  logic             err;

  logic [3:0]       d_digit;
  logic             d_cout;
  logic             d_invalid;
  logic [W-1:0]     shadow_next;
  logic             err_next;

  // The operand registers shift right, so the current digit is always at [3:0].
  bcd_digit_addsub u_digit (
    .xd      (x_sh[DIGIT_W-1:0]),
    .yd      (y_sh[DIGIT_W-1:0]),
    .cin     (carry),
    .sub     (sub_r),
    .digit   (d_digit),
    .cout    (d_cout),
    .invalid (d_invalid)
  );

  // New digit enters at the top of the shadow; after NDIGITS steps digit 0 sits at [3:0].
  always_comb begin
    shadow_next = (shadow >> DIGIT_W) | (W'(d_digit) << (W - DIGIT_W));
    err_next    = err | d_invalid;
  end

  assign ready = (state == IDLE);
  assign done  = (state == DONE);

  // FSM, digit counter, working registers and completion-time output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!reset_n) begin
      state        <= IDLE;
      cnt          <= '0;
      x_sh         <= '0;
      y_sh         <= '0;
      shadow       <= '0;
      carry        <= 1'b0;
      sub_r        <= 1'b0;
      err          <= 1'b0;
      result       <= '0;
      c_out        <= 1'b0;
      out_of_range <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            x_sh   <= X;
            y_sh   <= Y;
            sub_r  <= mode_sub;
            carry  <= mode_sub ? ~c_in : c_in;
            cnt    <= '0;
            shadow <= '0;
            err    <= 1'b0;
            state  <= RUN;
          end
        end
        RUN: begin
          x_sh   <= x_sh >> DIGIT_W;
          y_sh   <= y_sh >> DIGIT_W;
          shadow <= shadow_next;
          carry  <= d_cout;
          err    <= err_next;
          cnt    <= cnt + CNT_W'(1);
          if (cnt == LAST) begin
            state        <= DONE;
            result       <= err_next ? '0 : shadow_next;
            c_out        <= err_next ? 1'b0 : (sub_r ? ~d_cout : d_cout);
            out_of_range <= err_next;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_serial_addsub.sv
// Directed self-checking bench for bcd_serial_addsub with NDIGITS=4.
module tb_bcd_serial_addsub;

  localparam int ND = 4;
  localparam int W  = 4 * ND;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         start;
  logic         mode_sub;
  logic         c_in;
  logic [W-1:0] X;
  logic [W-1:0] Y;
  logic         ready;
  logic         done;
  logic [W-1:0] result;
  logic         c_out;
  logic         out_of_range;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bcd_serial_addsub #(.NDIGITS(ND)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .mode_sub     (mode_sub),
    .c_in         (c_in),
    .X            (X),
    .Y            (Y),
    .ready        (ready),
    .done         (done),
    .result       (result),
    .c_out        (c_out),
    .out_of_range (out_of_range)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One operation: wait for ready, launch, count edges to done, check outputs.
  // With poke set, start is re-pulsed with other operands during RUN.
  task automatic run_op(input string tag, input logic [15:0] x, input logic [15:0] y,
                        input logic sub, input logic cin, input logic [15:0] exp_r,
                        input logic exp_c, input logic exp_o, input bit poke);
    int k;
    int low;
    bit seen;
    for (int i = 0; i < 20 && !ready; i++) begin
      @(posedge clk); #1;
    end
    check({tag, "_ready_pre"}, 32'(ready), 32'd1);
    X = x; Y = y; mode_sub = sub; c_in = cin; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    low = (ready == 1'b0) ? 1 : 0;
    X = 16'h7777; Y = 16'h7777;
    seen = 1'b0;
    k = 0;
    while (!seen && k < 12) begin
      @(posedge clk); #1;
      k++;
      if (!ready) low++;
      if (done) seen = 1'b1;
      if (poke && k == 1) begin
        start = 1'b1; X = 16'h9999; Y = 16'h9999; mode_sub = ~sub;
      end
      if (poke && k == 3) start = 1'b0;
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    check({tag, "_latency"}, 32'(k), 32'd4);
    check({tag, "_ready_low"}, 32'(low), 32'd5);
    check({tag, "_result"}, 32'(result), 32'(exp_r));
    check({tag, "_c_out"}, 32'(c_out), 32'(exp_c));
    check({tag, "_oor"}, 32'(out_of_range), 32'(exp_o));
    @(posedge clk); #1;
    check({tag, "_done_drop"}, 32'(done), 32'd0);
    check({tag, "_ready_back"}, 32'(ready), 32'd1);
    check({tag, "_result_hold"}, 32'(result), 32'(exp_r));
  endtask

  initial begin
    int dcount;
    int pulses[$];
    int unstable;

    reset_n = 1'b0; start = 1'b0; mode_sub = 1'b0; c_in = 1'b0;
    X = '0; Y = '0;
    #12;
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_c_out", 32'(c_out), 32'd0);
    check("rst_oor", 32'(out_of_range), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;

    run_op("add1", 16'h1234, 16'h5678, 1'b0, 1'b0, 16'h6912, 1'b0, 1'b0, 1'b0);
    run_op("add2", 16'h9999, 16'h0001, 1'b0, 1'b1, 16'h0001, 1'b1, 1'b0, 1'b0);
    run_op("add0", 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    run_op("sub1", 16'h0003, 16'h0005, 1'b1, 1'b0, 16'h9998, 1'b1, 1'b0, 1'b0);
    run_op("sub2", 16'h5000, 16'h1234, 1'b1, 1'b1, 16'h3765, 1'b0, 1'b0, 1'b0);
    run_op("oor",  16'h12A4, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
    run_op("clr",  16'h2500, 16'h2500, 1'b0, 1'b0, 16'h5000, 1'b0, 1'b0, 1'b0);
    run_op("poke", 16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0, 1'b1);

    // Abort an operation mid-RUN with an asynchronous reset.
    X = 16'h1111; Y = 16'h2222; mode_sub = 1'b0; c_in = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    check("abort_ready", 32'(ready), 32'd1);
    check("abort_done", 32'(done), 32'd0);
    check("abort_result", 32'(result), 32'd0);
    check("abort_c_out", 32'(c_out), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    dcount = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (done) dcount++;
    end
    check("abort_no_done", 32'(dcount), 32'd0);
    run_op("post", 16'h0042, 16'h0058, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0);

    // Back-to-back operation with start held high.
    X = 16'h0250; Y = 16'h0250; mode_sub = 1'b0; c_in = 1'b0; start = 1'b1;
    unstable = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (done) pulses.push_back(i);
      if (pulses.size() > 0 && result !== 16'h0500) unstable++;
    end
    start = 1'b0;
    check("cont_pulses", 32'(pulses.size()), 32'd4);
    if (pulses.size() > 0) check("cont_first", 32'(pulses[0]), 32'd4);
    for (int i = 1; i < pulses.size(); i++)
      check("cont_period", 32'(pulses[i] - pulses[i-1]), 32'd6);
    check("cont_stable", 32'(unstable), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_serial_addsub.md
Name: bcd_serial_addsub

Overview:
- Parametrised, sequential successor to the single-digit combinational BCD adder.
- Adds or subtracts two packed N-digit BCD operands, one digit per clock, least-significant digit first.
- Start/ready/done handshake; results, carry/borrow and out-of-range flag are held registered until the next completion.
- Used wherever the datapath needs multi-digit decimal arithmetic without an N-digit combinational ripple.

Parameters:
NDIGITS, 4, number of BCD digits per operand/result (>=1)
CNT_W, $clog2(NDIGITS+1), width of the internal digit counter (derived; not overridden)

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous, active-low reset
start  input  1  request; accepted only when ready=1
mode_sub  input  1  0 = X+Y+c_in, 1 = X-Y-c_in (c_in acts as borrow-in)
c_in  input  1  carry-in (add) / borrow-in (sub)
X  input  4*NDIGITS  packed BCD operand, digit 0 in [3:0]
Y  input  4*NDIGITS  packed BCD operand
ready  output  1  high only in IDLE
done  output  1  one-cycle completion pulse
result  output  4*NDIGITS  packed BCD result
c_out  output  1  carry-out (add) / borrow-out (sub)
out_of_range  output  1  some operand digit was >9

Behaviour:
- Clock and reset: one clock `clk`; reset `reset_n` is asynchronous, active-low.
- Reset values: state=IDLE, ready=1, done=0, result=0, c_out=0, out_of_range=0, internal registers 0.
- FSM states: IDLE, RUN, DONE.
  - IDLE->RUN on start=1. On that edge, latch X, Y, mode_sub and c_in; counter=0.
  - Initial carry: add uses c_in; sub uses ~c_in.
  - Error latch: set if any digit of X or Y is in 10..15.
  - RUN: each edge processes digit[counter], then increments counter. After the edge that processes digit NDIGITS-1, go to DONE.
  - DONE: done=1 for exactly this one cycle, then unconditionally IDLE.
- Latency: start accepted at edge E0; digits processed at E1..EN; outputs update at EN; done high from EN to EN+1. ready is 0 from E0 to EN+1. Throughput is one op per NDIGITS+2 cycles.
- Per digit (sub-module):
  - yd' = yd for add, 9-yd for sub (nines complement).
  - s = xd + yd' + carry, computed 5 bits wide.
  - If s>9: digit=(s+6)[3:0], carry=1. Otherwise digit=s[3:0], carry=0.
- Completion:
  - Add: c_out = final carry.
  - Sub: c_out = ~final carry (borrow).
  - A negative difference appears as the ten's complement plus borrow=1, e.g. 0003-0005 = 9998, c_out=1.
- Out-of-range: result forced to 0, c_out=0, out_of_range=1. Latency is unchanged.
- Output registers (result, c_out, out_of_range) are written only at completion and hold between operations. Partial digits build in an internal shadow register and are never visible on the outputs.
- start while ready=0 is ignored (not queued). Operand changes after acceptance have no effect.
- reset_n low at any time (including mid-RUN or DONE) immediately returns everything to reset values. The aborted op produces no done.

Decomposition:
- Package bcd_pkg:
  - Constants: DIGIT_W=4, BCD_MAX=9, BCD_CORR=6.
  - State typedef/encoding: IDLE, RUN, DONE.
  - Function for nines complement.
- Sub-module bcd_digit_addsub: combinational single-digit cell.
  - Inputs: xd, yd, cin, sub.
  - Outputs: digit, cout, invalid.
- bcd_serial_addsub holds the FSM, counter, operand/shadow registers and output registers.

Test Plan:
- NDIGITS=4, add X=1234, Y=5678, c_in=0 -> result 6912, c_out=0, out_of_range=0; done 4 edges after the start edge; ready=0 for 5 cycles.
- Add X=9999, Y=0001, c_in=1 -> result 0001, c_out=1. Add 0000+0000, c_in=0 -> 0000, c_out=0.
- Sub X=0003, Y=0005, c_in=0 -> 9998, c_out=1. Sub X=5000, Y=1234, c_in=1 -> 3765, c_out=0.
- Add X=12A4 (digit 0xA), Y=0001 -> out_of_range=1, result 0000, c_out=0, same 4-edge latency. Next valid op clears out_of_range.
- Pulse start with new operands mid-RUN -> ignored, first result unchanged. Drive reset_n low during RUN -> outputs 0, ready=1 asynchronously, no done. A following op 0042+0058 -> 0100.
- Hold start=1 continuously with fixed operands -> done pulses every 6 cycles, result stable between pulses.
